// File: rtl/chunked_serial_adder_pkg.sv
// Shared types and sizing helpers for the chunked serial adder.
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Chunk index never narrower than one bit, even for single-cycle configs.
    function automatic int idx_width(input int width, input int chunk);
        int n;
        n = width / chunk;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunked_serial_adder_chunk.sv
// CHUNK-bit combinational ripple adder, shared across all chunks of a word.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout,
    output logic             o_cmsb
);

    logic w_carry;

    // o_cmsb is the carry entering the top bit; XOR with o_cout gives signed overflow.
    always_comb begin
        w_carry = i_cin;
        o_sum   = '0;
        o_cmsb  = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                o_cmsb = w_carry;
            end
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry;
            w_carry  = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_carry;
    end

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor: sums CHUNK bits per clock over WIDTH/CHUNK cycles,
// with carry/overflow/zero flags and valid/ready handshakes on both sides.
module chunked_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [1:0]       o_dbg_state
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDXW   = idx_width(WIDTH, CHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_cfg
            $error("chunked_serial_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [IDXW-1:0]  r_idx;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_chunk_sum;
    logic             w_chunk_cout;
    logic             w_chunk_cmsb;
    logic [WIDTH-1:0] w_sum_next;

    assign w_a_chunk = r_a[int'(r_idx) * CHUNK +: CHUNK];
    assign w_b_chunk = r_b[int'(r_idx) * CHUNK +: CHUNK];

    chunk_adder #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .i_a   (w_a_chunk),
        .i_b   (w_b_chunk),
        .i_cin (r_carry),
        .o_sum (w_chunk_sum),
        .o_cout(w_chunk_cout),
        .o_cmsb(w_chunk_cmsb)
    );

    // Full word as it will look once this cycle's chunk lands; feeds the zero flag.
    always_comb begin
        w_sum_next = r_sum;
        w_sum_next[int'(r_idx) * CHUNK +: CHUNK] = w_chunk_sum;
    end

    // Handshakes: a transfer happens on a rising clk edge where valid && ready.
    // Both ready and out_valid are registered and never depend on the peer's valid/ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        // Subtract as a + ~b + ~cin, so a set cin means borrow-in.
                        r_a        <= a;
                        r_b        <= sub ? ~b : b;
                        r_carry    <= sub ? ~cin : cin;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_chunk_cout;
                    if (r_idx == LAST_IDX) begin
                        r_cout      <= w_chunk_cout;
                        r_ovf       <= w_chunk_cmsb ^ w_chunk_cout;
                        r_zero      <= (w_sum_next == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_idx       <= '0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign sum         = r_sum;
    assign cout        = r_cout;
    assign ovf         = r_ovf;
    assign zero        = r_zero;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder in three configurations: 16/4, 32/32 and 8/1.
module tb_chunked_serial_adder;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- DUT signals ----------------
    logic        iv16, ir16, ov16, or16, cin16, sub16, cout16, ovf16, zero16;
    logic [15:0] a16, b16, sum16;
    logic [1:0]  st16;
    logic        iv32, ir32, ov32, or32, cin32, sub32, cout32, ovf32, zero32;
    logic [31:0] a32, b32, sum32;
    logic [1:0]  st32;
    logic        iv8, ir8, ov8, or8, cin8, sub8, cout8, ovf8, zero8;
    logic [7:0]  a8, b8, sum8;
    logic [1:0]  st8;

    chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(sum16),
        .cout(cout16), .ovf(ovf16), .zero(zero16), .o_dbg_state(st16));

    chunked_serial_adder #(.WIDTH(32), .CHUNK(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .sum(sum32),
        .cout(cout32), .ovf(ovf32), .zero(zero32), .o_dbg_state(st32));

    chunked_serial_adder #(.WIDTH(8), .CHUNK(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(sum8),
        .cout(cout8), .ovf(ovf8), .zero(zero8), .o_dbg_state(st8));

    int cfg_w[3] = '{16, 32, 8};
    int cfg_n[3] = '{4, 1, 8};

    // ---------------- reference model ----------------
    function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        longint m, ua, ub, sa, sb, ci, ur, sr;
        res_t r;
        m  = longint'(1) << w;
        ua = longint'(a) & (m - 1);
        ub = longint'(b) & (m - 1);
        ci = cin ? 1 : 0;
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        ur = sub ? ua - ub - ci : ua + ub + ci;
        sr = sub ? sa - sb - ci : sa + sb + ci;
        r.sum  = 32'(ur & (m - 1));
        r.cout = sub ? (ur >= 0) : (ur >= m);
        r.ovf  = (sr >= m / 2) || (sr < -(m / 2));
        r.zero = (r.sum == 32'h0);
        return r;
    endfunction

    function automatic logic [31:0] wmask(input int w);
        return 32'((longint'(1) << w) - 1);
    endfunction

    // ---------------- DUT access helpers ----------------
    function automatic logic get_ov(input int d);
        case (d)
            0: return ov16;
            1: return ov32;
            default: return ov8;
        endcase
    endfunction

    function automatic logic get_ir(input int d);
        case (d)
            0: return ir16;
            1: return ir32;
            default: return ir8;
        endcase
    endfunction

    function automatic res_t get_res(input int d);
        res_t r;
        case (d)
            0: r = '{sum: {16'h0, sum16}, cout: cout16, ovf: ovf16, zero: zero16};
            1: r = '{sum: sum32, cout: cout32, ovf: ovf32, zero: zero32};
            default: r = '{sum: {24'h0, sum8}, cout: cout8, ovf: ovf8, zero: zero8};
        endcase
        return r;
    endfunction

    task automatic set_in(input int d, input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic s);
        case (d)
            0: begin iv16 = v; a16 = a[15:0]; b16 = b[15:0]; cin16 = c; sub16 = s; end
            1: begin iv32 = v; a32 = a; b32 = b; cin32 = c; sub32 = s; end
            default: begin iv8 = v; a8 = a[7:0]; b8 = b[7:0]; cin8 = c; sub8 = s; end
        endcase
    endtask

    task automatic set_oready(input int d, input logic v);
        case (d)
            0: or16 = v;
            1: or32 = v;
            default: or8 = v;
        endcase
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One full transaction; junk is driven on the inputs while busy.
    task automatic txn(input int d, input logic [31:0] a, input logic [31:0] b, input logic c,
                       input logic s, output res_t r, output int lat);
        int guard;
        guard = 0;
        while (!get_ir(d) && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        set_in(d, 1'b1, a, b, c, s);
        @(posedge clk); #1;
        set_in(d, 1'b0, $urandom, $urandom, 1'($urandom), 1'($urandom));
        lat = 0;
        while (!get_ov(d) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        r = get_res(d);
        set_oready(d, 1'b1);
        @(posedge clk); #1;
        set_oready(d, 1'b0);
        check("post_handshake_valid", 64'(get_ov(d)), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    vec_t tbl[8];

    initial begin
        res_t r, e;
        int lat, guard, seen;
        logic [31:0] ra, rb;
        logic rc, rs;

        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};

        for (int d = 0; d < 3; d++) begin
            set_in(d, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            set_oready(d, 1'b0);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("reset_in_ready", 64'(get_ir(d)), 64'd1);
            check("reset_out_valid", 64'(get_ov(d)), 64'd0);
            check("reset_outputs", 64'(get_res(d)), 64'd0);
        end
        check("reset_state", 64'(st16), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors on the 16/4 configuration.
        for (int i = 0; i < 8; i++) begin
            txn(0, 32'(tbl[i].a), 32'(tbl[i].b), tbl[i].cin, tbl[i].sub, r, lat);
            check("vec_sum", 64'(r.sum), 64'(tbl[i].sum));
            check("vec_cout", 64'(r.cout), 64'(tbl[i].cout));
            check("vec_ovf", 64'(r.ovf), 64'(tbl[i].ovf));
            check("vec_zero", 64'(r.zero), 64'(tbl[i].zero));
            check("vec_latency", 64'(lat), 64'd4);
        end

        // Back-pressure: result held while out_ready is low, in_valid pulses ignored.
        set_in(0, 1'b1, 32'h1111, 32'h2222, 1'b0, 1'b0);
        @(posedge clk); #1;
        set_in(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        guard = 0;
        while (!ov16 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("bp_valid_rise", 64'(ov16), 64'd1);
        for (int k = 0; k < 5; k++) begin
            check("bp_hold_valid", 64'(ov16), 64'd1);
            check("bp_in_ready", 64'(ir16), 64'd0);
            check("bp_sum", 64'(sum16), 64'h3333);
            check("bp_flags", 64'({cout16, ovf16, zero16}), 64'd0);
            set_in(0, (k % 2 == 0), 32'hABCD, 32'h1234, 1'b1, 1'b1);
            @(posedge clk); #1;
        end
        set_in(0, 1'b1, 32'h0F0F, 32'h0101, 1'b0, 1'b0);
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
        check("bp_release_valid", 64'(ov16), 64'd0);
        check("bp_release_ready", 64'(ir16), 64'd1);
        check("bp_sum_retained", 64'(sum16), 64'h3333);
        @(posedge clk); #1;
        set_in(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("bp_next_accepted", 64'(ir16), 64'd0);
        guard = 0;
        while (!ov16 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("bp_next_sum", 64'(sum16), 64'h1010);
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;

        // Reset in the second busy cycle discards the in-flight result.
        set_in(0, 1'b1, 32'hFFFF, 32'hFFFF, 1'b1, 1'b0);
        @(posedge clk); #1;
        set_in(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 64'(ir16), 64'd1);
        check("mid_rst_out_valid", 64'(ov16), 64'd0);
        check("mid_rst_outputs", 64'(get_res(0)), 64'd0);
        check("mid_rst_state", 64'(st16), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ov16) seen++;
        end
        check("mid_rst_no_valid", 64'(seen), 64'd0);
        check("mid_rst_ready_after", 64'(ir16), 64'd1);
        txn(0, 32'h0102, 32'h0304, 1'b0, 1'b0, r, lat);
        check("mid_rst_fresh_sum", 64'(r.sum), 64'h0406);
        check("mid_rst_fresh_lat", 64'(lat), 64'd4);

        // Randomized compare against the arithmetic model on all three configurations.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < ((d == 0) ? 300 : 1000); i++) begin
                ra = $urandom & wmask(cfg_w[d]);
                rb = $urandom & wmask(cfg_w[d]);
                if ($urandom_range(0, 7) == 0) ra = wmask(cfg_w[d]);
                if ($urandom_range(0, 7) == 0) rb = (d == 2) ? 32'h80 : 32'h0;
                rc = 1'($urandom);
                rs = 1'($urandom);
                e = model(cfg_w[d], ra, rb, rc, rs);
                txn(d, ra, rb, rc, rs, r, lat);
                check("rnd_result", 64'(r), 64'(e));
                check("rnd_latency", 64'(lat), 64'(cfg_n[d]));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
